// File: rtl/alu_seq_if.sv
// alu_seq_if
//   Handshake and data bundle for the alu_seq execution unit.
//   Ports (master = issue side, slave = alu_seq):
//     in_valid    m->s  operands and opcode valid
//     in_ready    s->m  unit can accept
//     srcA, srcB  m->s  operands, WIDTH bits
//     ALUcontrol  m->s  4-bit opcode
//     out_valid   s->m  one-cycle result pulse
//     ALUResult   s->m  registered result, WIDTH bits
//     Zero, sign  s->m  flags derived from ALUResult
interface alu_seq_if #(
   parameter int WIDTH = 32
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] srcA;
   logic [WIDTH-1:0] srcB;
   logic [3:0]       ALUcontrol;
   logic             out_valid;
   logic [WIDTH-1:0] ALUResult;
   logic             Zero;
   logic             sign;

   modport master (
      output in_valid, srcA, srcB, ALUcontrol,
      input  in_ready, out_valid, ALUResult, Zero, sign
   );

   modport slave (
      input  in_valid, srcA, srcB, ALUcontrol,
      output in_ready, out_valid, ALUResult, Zero, sign
   );
endinterface

// File: rtl/alu_seq.sv
// alu_seq
//   WIDTH-bit execute-stage ALU with valid/ready handshake. Base ops finish
//   in one cycle; mul/mulhu/divu/remu iterate for WIDTH cycles while
//   in_ready is held low. Result and flags are registered.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    alu_seq_if.slave (handshake, operands, opcode, result, flags)
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | in_ready high; single-cycle ops complete on the accept edge
//   BUSY  | iterative op in flight, one shift-add / restoring step per cycle
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst_n,
   alu_seq_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [SHW-1:0]     count_q, count_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic               is_div_q, is_div_d;
   logic               hi_q, hi_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               out_valid_q, out_valid_d;

   logic               accept;
   logic               is_iter_op;
   logic [SHW-1:0]     shamt;
   logic [WIDTH-1:0]   alu_res;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] iter_next;

   assign accept     = bus.in_valid && (state_q == IDLE);
   assign is_iter_op = (bus.ALUcontrol[3:2] == 2'b10);
   assign shamt      = bus.srcB[SHW-1:0];

   always_comb begin
      alu_res = '0;
      case (bus.ALUcontrol)
         4'b0000: alu_res = bus.srcA + bus.srcB;
         4'b0001: alu_res = bus.srcA << shamt;
         4'b0010: alu_res = bus.srcA - bus.srcB;
         4'b0011: alu_res = WIDTH'($signed(bus.srcA) < $signed(bus.srcB));
         4'b0100: alu_res = bus.srcA ^ bus.srcB;
         4'b0101: alu_res = bus.srcA >> shamt;
         4'b0110: alu_res = bus.srcA | bus.srcB;
         4'b0111: alu_res = bus.srcA & bus.srcB;
         4'b1100: alu_res = $unsigned($signed(bus.srcA) >>> shamt);
         4'b1101: alu_res = WIDTH'(bus.srcA < bus.srcB);
         default: alu_res = '0;
      endcase
   end

   // Multiply: acc = {partial product, remaining multiplier bits}. Each step
   // conditionally adds the multiplicand into the upper half (carry kept in
   // the extra bit) and shifts the whole accumulator right.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
   assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                              : {1'b0, acc_q[2*WIDTH-1:1]};

   // Divide: acc = {remainder, dividend/quotient}. The quotient bit enters
   // at the bottom as dividend bits leave the top. With a zero divisor the
   // trial subtract never borrows, which naturally yields all-ones quotient
   // and the dividend as remainder.
   assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
   assign div_diff  = div_shift - {1'b0, opb_q};
   assign div_next  = div_diff[WIDTH]
                    ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                    : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

   assign iter_next = is_div_q ? div_next : mul_next;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      acc_d       = acc_q;
      opb_d       = opb_q;
      is_div_d    = is_div_q;
      hi_d        = hi_q;
      result_d    = result_q;
      out_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_iter_op) begin
                  acc_d    = {{WIDTH{1'b0}}, bus.srcA};
                  opb_d    = bus.srcB;
                  is_div_d = bus.ALUcontrol[1];
                  // mulhu and remu both read the upper accumulator half
                  hi_d     = bus.ALUcontrol[0];
                  count_d  = SHW'(WIDTH - 1);
                  state_d  = BUSY;
               end else begin
                  result_d    = alu_res;
                  out_valid_d = 1'b1;
               end
            end
         end
         BUSY: begin
            acc_d = iter_next;
            if (count_q == '0) begin
               result_d    = hi_q ? iter_next[2*WIDTH-1:WIDTH]
                                  : iter_next[WIDTH-1:0];
               out_valid_d = 1'b1;
               state_d     = IDLE;
            end else begin
               count_d = count_q - SHW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         count_q     <= '0;
         acc_q       <= '0;
         opb_q       <= '0;
         is_div_q    <= 1'b0;
         hi_q        <= 1'b0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         acc_q       <= acc_d;
         opb_q       <= opb_d;
         is_div_q    <= is_div_d;
         hi_q        <= hi_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.ALUResult = result_q;
   assign bus.Zero      = (result_q == '0);
   assign bus.sign      = result_q[WIDTH-1];
endmodule
